// File: rtl/cmd_queue.sv
// cmd_queue: assembles 4-word host commands into a FIFO and issues them one
// at a time to the control/sequencing block.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   soft_clr             synchronous flush of queue, assembler, FSM and flags
//   pipe_we, pipe_data   host pipe-in word strobe and 32-bit word
//   pipe_full, q_count   queue full flag and whole-command count
//   op_type, op_issue    issued opcode and one-cycle issue strobe
//   cmd_r_addr/w_addr/r_len  fields of the last issued command
//   op_done              current op finished (honoured only while busy)
//   busy, irq            op in flight; one-cycle queue-drained pulse
//   ovf, bad_op          sticky overflow / illegal-opcode flags
module cmd_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_clr,
  input  logic                     pipe_we,
  input  logic [31:0]              pipe_data,
  output logic                     pipe_full,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [2:0]               op_type,
  output logic                     op_issue,
  output logic [31:0]              cmd_r_addr,
  output logic [31:0]              cmd_w_addr,
  output logic [7:0]               cmd_r_len,
  input  logic                     op_done,
  output logic                     busy,
  output logic                     irq,
  output logic                     ovf,
  output logic                     bad_op
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  r_len;
    logic [31:0] r_addr;
    logic [31:0] w_addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      wcnt_q;
  cmd_t            asm_q;
  cmd_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q;
  logic [2:0]      op_type_q, op_type_d;
  logic            op_issue_q, op_issue_d;
  logic [31:0]     r_addr_q, w_addr_q;
  logic [7:0]      r_len_q;
  logic            busy_q;
  logic            irq_q, irq_d;
  logic            ovf_q, bad_op_q;

  logic            accept_c, push_c, pop_c, load_c, bad_set_c;
  cmd_t            head_c;

  // Words are accepted only when the queue can take a full command.
  assign accept_c = pipe_we & ~soft_clr & ~full_q;
  assign push_c   = accept_c & (wcnt_q == 2'd3);
  assign head_c   = mem_q[rd_ptr_q];

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    pop_c      = 1'b0;
    load_c     = 1'b0;
    bad_set_c  = 1'b0;
    op_issue_d = 1'b0;
    op_type_d  = 3'd0;
    irq_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop_c = 1'b1;
          case (head_c.op)
            3'd1, 3'd2, 3'd3, 3'd4: begin
              state_d    = ST_ISSUE;
              load_c     = 1'b1;
              op_issue_d = 1'b1;
              op_type_d  = head_c.op;
            end
            3'd0:    ;
            default: bad_set_c = 1'b1;
          endcase
        end
      end
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY: begin
        if (op_done) begin
          state_d = ST_IDLE;
          // No pop happens in BUSY, so the queue is empty after this cycle
          // exactly when it is empty now and nothing is pushed.
          irq_d = (count_q == '0) & ~push_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (soft_clr) begin
      state_d    = ST_IDLE;
      pop_c      = 1'b0;
      load_c     = 1'b0;
      bad_set_c  = 1'b0;
      op_issue_d = 1'b0;
      op_type_d  = 3'd0;
      irq_d      = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (soft_clr) count_d = '0;
  end

  // State, assembler, pointers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 2'd0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      op_type_q  <= 3'd0;
      op_issue_q <= 1'b0;
      r_addr_q   <= 32'd0;
      w_addr_q   <= 32'd0;
      r_len_q    <= 8'd0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bad_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      op_type_q  <= op_type_d;
      op_issue_q <= op_issue_d;
      busy_q     <= (state_d == ST_BUSY);
      irq_q      <= irq_d;
      if (soft_clr) begin
        wcnt_q   <= 2'd0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
        bad_op_q <= 1'b0;
      end else begin
        if (accept_c) begin
          wcnt_q <= wcnt_q + 2'd1;
          case (wcnt_q)
            2'd0: begin
              asm_q.op    <= pipe_data[2:0];
              asm_q.r_len <= pipe_data[15:8];
            end
            2'd1:    asm_q.r_addr <= pipe_data;
            2'd2:    asm_q.w_addr <= pipe_data;
            default: ;
          endcase
        end
        if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
        ovf_q    <= ovf_q | (pipe_we & full_q);
        bad_op_q <= bad_op_q | bad_set_c;
      end
      if (load_c) begin
        r_addr_q <= head_c.r_addr;
        w_addr_q <= head_c.w_addr;
        r_len_q  <= head_c.r_len;
      end
    end
  end

  // Command storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= asm_q;
  end

  assign pipe_full  = full_q;
  assign q_count    = count_q;
  assign op_type    = op_type_q;
  assign op_issue   = op_issue_q;
  assign cmd_r_addr = r_addr_q;
  assign cmd_w_addr = w_addr_q;
  assign cmd_r_len  = r_len_q;
  assign busy       = busy_q;
  assign irq        = irq_q;
  assign ovf        = ovf_q;
  assign bad_op     = bad_op_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Self-checking bench for cmd_queue: scoreboard of expected issued commands,
// checked by a negedge monitor, plus directed latency/flag checks.
module tb_cmd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_clr = 1'b0;
  logic        pipe_we = 1'b0;
  logic [31:0] pipe_data = 32'd0;
  logic        pipe_full;
  logic [3:0]  q_count;
  logic [2:0]  op_type;
  logic        op_issue;
  logic [31:0] cmd_r_addr, cmd_w_addr;
  logic [7:0]  cmd_r_len;
  logic        op_done = 1'b0;
  logic        busy, irq, ovf, bad_op;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  rlen;
    logic [31:0] ra;
    logic [31:0] wa;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_issued = 0;
  int   n_irq = 0;

  cmd_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .pipe_we(pipe_we), .pipe_data(pipe_data),
    .pipe_full(pipe_full), .q_count(q_count),
    .op_type(op_type), .op_issue(op_issue),
    .cmd_r_addr(cmd_r_addr), .cmd_w_addr(cmd_w_addr), .cmd_r_len(cmd_r_len),
    .op_done(op_done), .busy(busy), .irq(irq), .ovf(ovf), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issued-command monitor against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_issue) begin
        n_issued++;
        if (sb.size() == 0) begin
          check_eq("spurious_issue", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("op_type", 32'(op_type), 32'(mon_e.op));
          check_eq("r_len", 32'(cmd_r_len), 32'(mon_e.rlen));
          check_eq("r_addr", cmd_r_addr, mon_e.ra);
          check_eq("w_addr", cmd_w_addr, mon_e.wa);
        end
      end
      if (irq) n_irq++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    pipe_we   = 1'b1;
    pipe_data = d;
    tick();
    pipe_we   = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] rlen,
                          input logic [31:0] ra, input logic [31:0] wa, input bit exp_push);
    exp_t e;
    e = '{op: op, rlen: rlen, ra: ra, wa: wa};
    send_word({16'hABCD, rlen, 5'b10101, op});
    send_word(ra);
    send_word(wa);
    if (exp_push) sb.push_back(e);
    send_word(32'hDEAD_BEEF);
  endtask

  // Wait for an issue strobe, then step into the BUSY cycle.
  task automatic issue_wait();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (op_issue) got = 1'b1;
    end
    check_eq("issue_seen", 32'(got), 32'd1);
    tick();
    check_eq("busy_after_issue", 32'(busy), 32'd1);
  endtask

  // Pulse op_done; either the next op issues two cycles later or irq pulses.
  task automatic done_expect(input bit next);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    check_eq("gap_no_issue", 32'(op_issue), 32'd0);
    if (next) begin
      check_eq("no_irq_yet", 32'(irq), 32'd0);
      tick();
      check_eq("issue_n_plus_2", 32'(op_issue), 32'd1);
      tick();
      check_eq("busy_next", 32'(busy), 32'd1);
    end else begin
      check_eq("irq_pulse", 32'(irq), 32'd1);
      check_eq("busy_clear", 32'(busy), 32'd0);
      tick();
      check_eq("irq_single", 32'(irq), 32'd0);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_full"}, 32'(pipe_full), 32'd0);
    check_eq({tag, "_count"}, 32'(q_count), 32'd0);
    check_eq({tag, "_optype"}, 32'(op_type), 32'd0);
    check_eq({tag, "_issue"}, 32'(op_issue), 32'd0);
    check_eq({tag, "_raddr"}, cmd_r_addr, 32'd0);
    check_eq({tag, "_waddr"}, cmd_w_addr, 32'd0);
    check_eq({tag, "_rlen"}, 32'(cmd_r_len), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_irq"}, 32'(irq), 32'd0);
    check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
    check_eq({tag, "_badop"}, 32'(bad_op), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq0;
    int iss0;
    exp_t z;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic single command with the documented word values.
    sb.push_back('{op: 3'd1, rlen: 8'h10, ra: 32'h0029_0000, wa: 32'h002E_0000});
    send_word(32'h0000_1001);
    send_word(32'h0029_0000);
    send_word(32'h002E_0000);
    send_word(32'h0000_0000);
    check_eq("count_one", 32'(q_count), 32'd1);
    tick();
    check_eq("issue_latency", 32'(op_issue), 32'd1);
    check_eq("issue_optype", 32'(op_type), 32'd1);
    tick();
    check_eq("busy_on", 32'(busy), 32'd1);
    check_eq("optype_idle", 32'(op_type), 32'd0);
    check_eq("rlen_hold", 32'(cmd_r_len), 32'h10);
    done_expect(1'b0);

    // Three commands queued while busy, issued in order.
    send_cmd(3'd1, 8'h01, 32'h1000_0000, 32'h2000_0000, 1'b1);
    issue_wait();
    send_cmd(3'd3, 8'h22, 32'h1111_1111, 32'h2222_2222, 1'b1);
    send_cmd(3'd4, 8'h33, 32'h3333_3333, 32'h4444_4444, 1'b1);
    send_cmd(3'd2, 8'h44, 32'h5555_5555, 32'h6666_6666, 1'b1);
    irq0 = n_irq;
    done_expect(1'b1);
    done_expect(1'b1);
    done_expect(1'b1);
    check_eq("no_early_irq", 32'(n_irq), 32'(irq0));
    done_expect(1'b0);

    // Fill the queue with op_done withheld, then overflow.
    iss0 = n_issued;
    for (int i = 0; i < 9; i++) begin
      send_cmd(3'((i % 4) + 1), 8'(i * 3 + 5), $urandom, $urandom, 1'b1);
      if (i == 7) begin
        check_eq("count_seven", 32'(q_count), 32'd7);
        check_eq("not_full_seven", 32'(pipe_full), 32'd0);
        check_eq("one_issued", 32'(n_issued - iss0), 32'd1);
      end
    end
    check_eq("count_full", 32'(q_count), 32'd8);
    check_eq("pipe_full", 32'(pipe_full), 32'd1);
    send_cmd(3'd2, 8'hEE, 32'hBAD0_0000, 32'hBAD1_0000, 1'b0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("count_after_ovf", 32'(q_count), 32'd8);
    for (int i = 0; i < 8; i++) done_expect(1'b1);
    done_expect(1'b0);

    // Opcode 000 dropped silently, 110 flagged, 001 issued.
    iss0 = n_issued;
    send_cmd(3'd0, 8'h07, 32'h0000_0A00, 32'h0000_0B00, 1'b0);
    send_cmd(3'd6, 8'h08, 32'h0000_0C00, 32'h0000_0D00, 1'b0);
    send_cmd(3'd1, 8'h09, 32'h0000_0E00, 32'h0000_0F00, 1'b1);
    issue_wait();
    check_eq("bad_op_set", 32'(bad_op), 32'd1);
    check_eq("only_one_issue", 32'(n_issued - iss0), 32'd1);
    done_expect(1'b0);

    // Push of w3 coinciding with a pop at q_count == 1.
    send_cmd(3'd2, 8'h51, 32'h5100_0000, 32'h5200_0000, 1'b1);
    issue_wait();
    send_cmd(3'd3, 8'h61, 32'h6100_0000, 32'h6200_0000, 1'b1);
    z = '{op: 3'd4, rlen: 8'h71, ra: 32'h7100_0000, wa: 32'h7200_0000};
    send_word({16'h0, z.rlen, 5'd0, z.op});
    send_word(z.ra);
    send_word(z.wa);
    sb.push_back(z);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    pipe_we = 1'b1;
    pipe_data = 32'h0;
    tick();
    pipe_we = 1'b0;
    check_eq("push_pop_count", 32'(q_count), 32'd1);
    check_eq("push_pop_issue", 32'(op_issue), 32'd1);
    tick();
    done_expect(1'b1);
    done_expect(1'b0);

    // soft_clr with three commands queued and an op in flight.
    send_cmd(3'd1, 8'h81, 32'h8100_0000, 32'h8200_0000, 1'b1);
    issue_wait();
    for (int i = 0; i < 3; i++)
      send_cmd(3'd2, 8'(i), 32'(i), 32'(i + 16), 1'b0);
    check_eq("pre_clr_count", 32'(q_count), 32'd3);
    check_eq("pre_clr_ovf", 32'(ovf), 32'd1);
    soft_clr = 1'b1;
    pipe_we = 1'b1;
    pipe_data = 32'h0000_0001;
    tick();
    soft_clr = 1'b0;
    pipe_we = 1'b0;
    check_eq("clr_count", 32'(q_count), 32'd0);
    check_eq("clr_ovf", 32'(ovf), 32'd0);
    check_eq("clr_bad_op", 32'(bad_op), 32'd0);
    check_eq("clr_busy", 32'(busy), 32'd0);
    iss0 = n_issued;
    irq0 = n_irq;
    repeat (6) tick();
    check_eq("clr_no_issue", 32'(n_issued), 32'(iss0));
    check_eq("clr_no_irq", 32'(n_irq), 32'(irq0));
    send_cmd(3'd4, 8'h91, 32'h9100_0000, 32'h9200_0000, 1'b1);
    issue_wait();
    done_expect(1'b0);

    // Reset in the middle of a command; next command must be aligned.
    send_word(32'h0000_0102);
    send_word(32'hCAFE_0000);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_cmd(3'd3, 8'hA5, 32'hA500_0000, 32'hA600_0000, 1'b1);
    issue_wait();
    done_expect(1'b0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
